// File: rtl/fifo_byte_drain.sv
// ---------------------------------------------------------------------------
// fifo_byte_drain
//
// Read-side consumer for a 36-bit first-word-fall-through FIFO. Each popped
// word is serialised LSB byte first onto a byte-wide valid/ready stream with
// packet framing. The block also keeps running byte and packet counters.
// Everything runs on the FIFO read clock.
//
// Ports
//   CLK        in   1   FIFO read clock
//   RST_N      in   1   synchronous active-low reset
//   DO         in  36   FIFO head word: [31:0] data, [32] reserved,
//                       [34:33] valid byte count - 1, [35] END of packet
//   EMPTY      in   1   FIFO empty; DO is valid only when EMPTY=0
//   RDEN       out  1   pop strobe (combinational, never set while EMPTY=1)
//   OUT_DATA   out  8   stream byte
//   OUT_VALID  out  1   stream byte valid
//   OUT_LAST   out  1   last byte of the packet, qualified by OUT_VALID
//   OUT_READY  in   1   sink accepts the byte
//   BYTE_COUNT out 32   bytes accepted by the sink, wraps
//   PKT_COUNT  out  PKT_COUNT_WIDTH   packets completed, wraps
// ---------------------------------------------------------------------------
module fifo_byte_drain #(
    parameter int PKT_COUNT_WIDTH = 16
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic [35:0]                DO,
    input  logic                       EMPTY,
    output logic                       RDEN,
    output logic [7:0]                 OUT_DATA,
    output logic                       OUT_VALID,
    output logic                       OUT_LAST,
    input  logic                       OUT_READY,
    output logic [31:0]                BYTE_COUNT,
    output logic [PKT_COUNT_WIDTH-1:0] PKT_COUNT
);

    // The busy flag is the only control state: IDLE waits for a word,
    // BUSY presents bytes of the currently loaded word.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [31:0]                sr_q, sr_d;
    logic [1:0]                 rem_q, rem_d;
    logic                       end_q, end_d;
    logic                       last_q, last_d;
    logic [31:0]                byte_cnt_q;
    logic [PKT_COUNT_WIDTH-1:0] pkt_cnt_q;

    logic take;
    logic word_done;
    logic load;

    // Bit 32 of the FIFO word carries nothing for this consumer.
    logic unused_rsv;
    assign unused_rsv = DO[32];

    // -----------------------------------------------------------------------
    // Next-state / pop decision
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        rem_d     = rem_q;
        end_d     = end_q;
        take      = (state_q == S_BUSY) & OUT_READY;
        word_done = take & (rem_q == 2'd0);
        // Reload in the same cycle the final byte is accepted, so words
        // stream back to back. Pops are suppressed while reset is held.
        load      = RST_N & ~EMPTY & ((state_q == S_IDLE) | word_done);

        if (load) begin
            sr_d    = DO[31:0];
            rem_d   = DO[34:33];
            end_d   = DO[35];
            state_d = S_BUSY;
        end else if (take && (rem_q != 2'd0)) begin
            sr_d  = {8'h00, sr_q[31:8]};
            rem_d = rem_q - 2'd1;
        end else if (word_done) begin
            // Only reached when the FIFO is empty (otherwise load wins).
            state_d = S_IDLE;
        end

        // OUT_LAST is registered from the next-state view so that every
        // stream output comes straight from a flop.
        last_d = (state_d == S_BUSY) & end_d & (rem_d == 2'd0);
    end

    // -----------------------------------------------------------------------
    // State and counters
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            sr_q       <= '0;
            rem_q      <= '0;
            end_q      <= 1'b0;
            last_q     <= 1'b0;
            byte_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            rem_q      <= rem_d;
            end_q      <= end_d;
            last_q     <= last_d;
            byte_cnt_q <= byte_cnt_q + {31'd0, take};
            pkt_cnt_q  <= pkt_cnt_q + {{(PKT_COUNT_WIDTH-1){1'b0}}, take & last_q};
        end
    end

    assign RDEN       = load;
    assign OUT_VALID  = (state_q == S_BUSY);
    assign OUT_DATA   = sr_q[7:0];
    assign OUT_LAST   = last_q;
    assign BYTE_COUNT = byte_cnt_q;
    assign PKT_COUNT  = pkt_cnt_q;

endmodule
